// File: rtl/alu_datapath.sv
// alu_datapath: operand/result registers, single-cycle ALU ops and status flags for the ALU controller.
// Define ALU_MUL_EN to make opcode B a multi-cycle shift-add multiply; otherwise it writes Y=0.
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_A,
  input  logic             enable_B,
  input  logic             enable_Y,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] reg_A,
  output logic [WIDTH-1:0] reg_B,
  output logic [WIDTH-1:0] result_Y,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] a, b, y, hi, y_n;
  logic             fz, fn, fc, fv, dn, c_n, v_n, go, is_mul;
  logic [WIDTH:0]   sum, dif, inc, dec;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign inc = {1'b0, a} + 1'b1;
  assign dec = {1'b0, a} - 1'b1;
  assign go  = enable_Y && !busy;
  assign reg_A     = a;
  assign reg_B     = b;
  assign result_Y  = y;
  assign result_hi = hi;
  assign flag_z    = fz;
  assign flag_n    = fn;
  assign flag_c    = fc;
  assign flag_v    = fv;
  assign done      = dn;
  always_comb begin
    y_n = '0;
    c_n = 1'b0;
    v_n = 1'b0;
    case (operation)
      4'h0: begin y_n = sum[M:0]; c_n = sum[WIDTH]; v_n = (a[M] == b[M]) && (sum[M] != a[M]); end
      4'h1: begin y_n = dif[M:0]; c_n = dif[WIDTH]; v_n = (a[M] != b[M]) && (dif[M] != a[M]); end
      4'h2: y_n = a & b;
      4'h3: y_n = a | b;
      4'h4: y_n = a ^ b;
      4'h5: y_n = ~a;
      4'h6: begin y_n = {a[M-1:0], 1'b0}; c_n = a[M]; end
      4'h7: begin y_n = {1'b0, a[M:1]};   c_n = a[0]; end
      4'h8: begin y_n = {a[M], a[M:1]};   c_n = a[0]; end
      4'h9: begin y_n = {a[M-1:0], a[M]}; c_n = a[M]; end
      4'hA: begin y_n = {a[0], a[M:1]};   c_n = a[0]; end
      4'hC: begin y_n = inc[M:0]; c_n = inc[WIDTH]; v_n = inc[M] & ~a[M]; end
      4'hD: begin y_n = dec[M:0]; c_n = dec[WIDTH]; v_n = a[M] & ~dec[M]; end
      4'hE: y_n = b;
      4'hF: y_n = a;
      default: y_n = '0;
    endcase
  end
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic                 mb, mul_end;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mc, acc, acc_n;
  logic [WIDTH-1:0]     mp;
  assign is_mul  = operation == 4'hB;
  assign busy    = mb;
  assign acc_n   = mp[0] ? acc + mc : acc;
  assign mul_end = cnt == CW'(WIDTH - 1);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a  <= '0;
      b  <= '0;
      y  <= '0;
      hi <= '0;
      fz <= 1'b0;
      fn <= 1'b0;
      fc <= 1'b0;
      fv <= 1'b0;
      dn <= 1'b0;
`ifdef ALU_MUL_EN
      mb  <= 1'b0;
      cnt <= '0;
      mc  <= '0;
      mp  <= '0;
      acc <= '0;
`endif
    end else begin
      dn <= 1'b0;
      if (enable_A) a <= data_in;
      if (enable_B) b <= data_in;
      if (go && !is_mul) begin
        y  <= y_n;
        hi <= '0;
        fz <= y_n == '0;
        fn <= y_n[M];
        fc <= c_n;
        fv <= v_n;
        dn <= 1'b1;
      end
`ifdef ALU_MUL_EN
      // operands are snapshotted at start so later A/B loads cannot disturb the product
      if (go && is_mul) begin
        mb  <= 1'b1;
        cnt <= '0;
        mc  <= {{WIDTH{1'b0}}, a};
        mp  <= b;
        acc <= '0;
      end else if (mb) begin
        acc <= acc_n;
        mc  <= mc << 1;
        mp  <= mp >> 1;
        cnt <= cnt + 1'b1;
        if (mul_end) begin
          mb <= 1'b0;
          y  <= acc_n[M:0];
          hi <= acc_n[2*WIDTH-1:WIDTH];
          fz <= acc_n[M:0] == '0;
          fn <= acc_n[M];
          fc <= |acc_n[2*WIDTH-1:WIDTH];
          fv <= 1'b0;
          dn <= 1'b1;
        end
      end
`endif
    end
endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: vector table, handshake sequences and randomized run against an arithmetic model.
module tb_alu_datapath;
  logic       clk = 1'b0, reset = 1'b1;
  logic       enable_A = 1'b0, enable_B = 1'b0, enable_Y = 1'b0;
  logic [3:0] operation = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] reg_A, reg_B, result_Y, result_hi;
  logic       flag_z, flag_n, flag_c, flag_v, busy, done;
  int         n_vec = 0, n_fail = 0;

  alu_datapath #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable_A(enable_A), .enable_B(enable_B), .enable_Y(enable_Y),
    .operation(operation), .data_in(data_in), .reg_A(reg_A), .reg_B(reg_B),
    .result_Y(result_Y), .result_hi(result_hi), .flag_z(flag_z), .flag_n(flag_n),
    .flag_c(flag_c), .flag_v(flag_v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, y;
    logic       z, n, c, v;
  } vec_t;

  function automatic logic [21:0] obs();
    return {result_Y, result_hi, flag_z, flag_n, flag_c, flag_v, busy, done};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ea, input logic eb, input logic ey, input logic [3:0] op, input logic [7:0] d);
    enable_A = ea; enable_B = eb; enable_Y = ey; operation = op; data_in = d;
    @(posedge clk); #1;
    enable_A = 1'b0; enable_B = 1'b0; enable_Y = 1'b0;
  endtask

  task automatic calc(input int op, input int a, input int b, output int y, output int c, output int v);
    int sa, sb, sr;
    sa = a > 127 ? a - 256 : a;
    sb = b > 127 ? b - 256 : b;
    y = 0; c = 0; v = 0;
    case (op)
      0: begin y = (a + b) % 256; c = int'(a + b > 255); sr = sa + sb; v = int'(sr > 127 || sr < -128); end
      1: begin y = (a - b + 256) % 256; c = int'(a < b); sr = sa - sb; v = int'(sr > 127 || sr < -128); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 255 - a;
      6: begin y = (a * 2) % 256; c = a / 128; end
      7: begin y = a / 2; c = a % 2; end
      8: begin y = a / 2 + (a / 128) * 128; c = a % 2; end
      9: begin y = (a * 2) % 256 + a / 128; c = a / 128; end
      10: begin y = a / 2 + (a % 2) * 128; c = a % 2; end
      12: begin y = (a + 1) % 256; c = int'(a == 255); v = int'(a == 127); end
      13: begin y = (a + 255) % 256; c = int'(a == 0); v = int'(a == 128); end
      14: y = b;
      15: y = a;
      default: y = 0;
    endcase
  endtask

  initial begin
    vec_t vt[20];
    int   cyc, y, c, v;
    int   mA, mB, mY, mZ, mN, mC, mV, mD;
    logic [7:0] y_before;
    vt[0]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 0, 1, 0, 1};
    vt[1]  = '{4'h1, 8'h05, 8'h05, 8'h00, 1, 0, 0, 0};
    vt[2]  = '{4'h1, 8'h03, 8'h05, 8'hFE, 0, 1, 1, 0};
    vt[3]  = '{4'h6, 8'h81, 8'h00, 8'h02, 0, 0, 1, 0};
    vt[4]  = '{4'hA, 8'h81, 8'h00, 8'hC0, 0, 1, 1, 0};
    vt[5]  = '{4'h8, 8'h81, 8'h00, 8'hC0, 0, 1, 1, 0};
    vt[6]  = '{4'h7, 8'h81, 8'h00, 8'h40, 0, 0, 1, 0};
    vt[7]  = '{4'h9, 8'h81, 8'h00, 8'h03, 0, 0, 1, 0};
    vt[8]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0};
    vt[9]  = '{4'h3, 8'hF0, 8'h3C, 8'hFC, 0, 1, 0, 0};
    vt[10] = '{4'h4, 8'hF0, 8'h3C, 8'hCC, 0, 1, 0, 0};
    vt[11] = '{4'h5, 8'h0F, 8'h00, 8'hF0, 0, 1, 0, 0};
    vt[12] = '{4'hC, 8'hFF, 8'h00, 8'h00, 1, 0, 1, 0};
    vt[13] = '{4'hC, 8'h7F, 8'h00, 8'h80, 0, 1, 0, 1};
    vt[14] = '{4'hD, 8'h00, 8'h00, 8'hFF, 0, 1, 1, 0};
    vt[15] = '{4'hD, 8'h80, 8'h00, 8'h7F, 0, 0, 0, 1};
    vt[16] = '{4'hE, 8'h12, 8'hA5, 8'hA5, 0, 1, 0, 0};
    vt[17] = '{4'hF, 8'h12, 8'hA5, 8'h12, 0, 0, 0, 0};
    vt[18] = '{4'h0, 8'hFF, 8'h01, 8'h00, 1, 0, 1, 0};
    vt[19] = '{4'h1, 8'h80, 8'h01, 8'h7F, 0, 0, 0, 1};

    #1;
    chk("reset_outputs", {reg_A, reg_B, obs()}, 38'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      step(1, 0, 0, 4'h0, vt[i].a);
      step(0, 1, 0, 4'h0, vt[i].b);
      step(0, 0, 1, vt[i].op, 8'h00);
      chk($sformatf("vec%0d_op%h", i, vt[i].op), obs(),
          {vt[i].y, 8'h00, vt[i].z, vt[i].n, vt[i].c, vt[i].v, 1'b0, 1'b1});
      step(0, 0, 0, 4'h0, 8'h00);
      chk($sformatf("vec%0d_done_drop", i), {result_Y, done}, {vt[i].y, 1'b0});
    end

    step(1, 0, 0, 4'h0, 8'h01);
    step(0, 1, 0, 4'h0, 8'h01);
    step(1, 0, 1, 4'h0, 8'h10);
    chk("simul_load_old_a", {result_Y, done}, {8'h02, 1'b1});
    chk("simul_load_new_a", reg_A, 8'h10);

`ifdef ALU_MUL_EN
    step(1, 0, 0, 4'h0, 8'hFF);
    step(0, 1, 0, 4'h0, 8'hFF);
    y_before = result_Y;
    step(0, 0, 1, 4'hB, 8'h00);
    chk("mul_start_busy", {busy, done, result_Y}, {1'b1, 1'b0, y_before});
    cyc = 0;
    while (busy && cyc < 20) begin
      step(cyc == 3, 0, cyc == 2, 4'h0, 8'h00);
      cyc++;
      if (cyc == 3) chk("mul_ey_ignored", {busy, done, result_Y}, {1'b1, 1'b0, y_before});
    end
    chk("mul_busy_cycles", cyc, 8);
    chk("mul_ff_ff", obs(), {8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("mul_load_during_busy", reg_A, 8'h00);
    step(0, 0, 0, 4'h0, 8'h00);
    chk("mul_done_drop", {done, busy}, 2'b00);
    step(0, 0, 1, 4'h0, 8'h00);
    chk("hi_cleared_by_add", obs(), {8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    step(0, 0, 1, 4'hB, 8'h00);
    step(0, 0, 0, 4'h0, 8'h00);
    step(0, 0, 0, 4'h0, 8'h00);
    #2 reset = 1'b1;
    #1 chk("reset_mid_mul", {reg_A, reg_B, obs()}, 38'h0);
    @(negedge clk); reset = 1'b0;
    step(1, 0, 0, 4'h0, 8'h03);
    step(0, 1, 0, 4'h0, 8'h04);
    step(0, 0, 1, 4'hB, 8'h00);
    cyc = 0;
    while (busy && cyc < 20) begin
      step(0, 0, 0, 4'h0, 8'h00);
      cyc++;
    end
    chk("mul2_busy_cycles", cyc, 8);
    chk("mul_3x4", obs(), {8'h0C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    step(1, 0, 0, 4'h0, 8'hFF);
    step(0, 1, 0, 4'h0, 8'hFF);
    step(0, 0, 1, 4'hB, 8'h00);
    chk("opB_no_mul", obs(), {8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step(0, 0, 1, 4'hF, 8'h00);
    #2 reset = 1'b1;
    #1 chk("reset_async", {reg_A, reg_B, obs()}, 38'h0);
`endif

    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    mA = 0; mB = 0; mY = 0; mZ = 0; mN = 0; mC = 0; mV = 0; mD = 0;
    for (int i = 0; i < 400; i++) begin
      logic ea, eb, ey;
      logic [3:0] op;
      logic [7:0] d;
      ea = 1'($urandom_range(1));
      eb = 1'($urandom_range(1));
      ey = 1'($urandom_range(1));
      op = 4'($urandom_range(15));
`ifdef ALU_MUL_EN
      if (op == 4'hB) op = 4'h0;
`endif
      d = 8'($urandom_range(255));
      step(ea, eb, ey, op, d);
      mD = int'(ey);
      if (ey) begin
        calc(int'(op), mA, mB, y, c, v);
        mY = y; mZ = int'(y == 0); mN = int'(y > 127); mC = c; mV = v;
      end
      if (ea) mA = int'(d);
      if (eb) mB = int'(d);
      chk($sformatf("rand%0d_op%h", i, op), {reg_A, reg_B, obs()},
          {8'(mA), 8'(mB), 8'(mY), 8'h00, 1'(mZ), 1'(mN), 1'(mC), 1'(mV), 1'b0, 1'(mD)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
